// File: rtl/hazard_ctrl_unit.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl_unit
//  Description : Hazard control for a five-stage in-order pipeline.
//                - Per-operand forwarding select for the execute stage.
//                - Load-use stall sequencing. A stall lasts LOAD_LAT cycles.
//                - Branch flush.
//                - Whole-pipeline freeze while the cache is busy. The stall
//                  context is saved and restored around the freeze.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    NUM_SRC   source operands per instruction (1..3)
//    REG_AW    register address width
//    LOAD_LAT  load-use stall cycles (1..4)
//  Ports
//    clk, rst            clock (rising edge); asynchronous active-low reset
//    Rs_D, Rs_E          packed decode/execute source addresses
//    RD_E/M/W            destination registers of the E, M and W stages
//    RegWriteE/M/W       write enables of the E, M and W stages
//    ResultSrcE          the execute-stage instruction is a load
//    PCSrcE              branch/jump taken, resolved in execute
//    o_p_waitrequest     the cache is busy, so the whole pipeline holds
//    Forward_E           per-operand select: 00 regfile, 10 from M, 01 from W
//    StallF, StallD      hold the PC and the F/D register
//    FlushD, FlushE      clear the F/D and D/E registers
//    FreezeEMW           hold the D/E, E/M and M/W registers
//  Optional feature (macro HAZARD_PERF_CNT_EN)
//    perf_clr            synchronous clear of the performance counters
//    stall_cnt           cycles with StallF high (saturating)
//    flush_cnt           cycles with FlushD high (saturating)
// ============================================================================
module hazard_ctrl_unit #(
    parameter int NUM_SRC  = 2,
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_SRC*REG_AW-1:0]   Rs_D,
    input  logic [NUM_SRC*REG_AW-1:0]   Rs_E,
    input  logic [REG_AW-1:0]           RD_E,
    input  logic                        RegWriteE,
    input  logic                        ResultSrcE,
    input  logic [REG_AW-1:0]           RD_M,
    input  logic                        RegWriteM,
    input  logic [REG_AW-1:0]           RD_W,
    input  logic                        RegWriteW,
    input  logic                        PCSrcE,
    input  logic                        o_p_waitrequest,
`ifdef HAZARD_PERF_CNT_EN
    input  logic                        perf_clr,
    output logic [31:0]                 stall_cnt,
    output logic [31:0]                 flush_cnt,
`endif
    output logic [2*NUM_SRC-1:0]        Forward_E,
    output logic                        StallF,
    output logic                        StallD,
    output logic                        FlushD,
    output logic                        FlushE,
    output logic                        FreezeEMW
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [1:0] c_ST_RUN  = 2'd0;
    localparam logic [1:0] c_ST_LU   = 2'd1;
    localparam logic [1:0] c_ST_WAIT = 2'd2;

    // The RUN cycle that detects the hazard is the first stall cycle.
    // LU_STALL therefore covers the remaining LOAD_LAT-1 cycles.
    localparam logic [2:0] c_LU_INIT = 3'(LOAD_LAT - 1);
    localparam bit         c_MULTI   = (LOAD_LAT > 1);

    // ------------------------------------------------------------------
    // Forwarding (purely combinational; the M stage beats the W stage)
    // ------------------------------------------------------------------
    logic [NUM_SRC-1:0] w_src_match;

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_fwd
        logic [REG_AW-1:0] w_rs_e;
        logic [REG_AW-1:0] w_rs_d;
        logic              w_hit_m;
        logic              w_hit_w;

        assign w_rs_e  = Rs_E[gi*REG_AW +: REG_AW];
        assign w_rs_d  = Rs_D[gi*REG_AW +: REG_AW];
        assign w_hit_m = RegWriteM && (RD_M != '0) && (RD_M == w_rs_e);
        assign w_hit_w = RegWriteW && (RD_W != '0) && (RD_W == w_rs_e);

        assign Forward_E[2*gi +: 2] = w_hit_m ? 2'b10 :
                                      w_hit_w ? 2'b01 : 2'b00;

        assign w_src_match[gi] = (w_rs_d == RD_E);
    end

    logic w_load_use;
    assign w_load_use = ResultSrcE && RegWriteE && (RD_E != '0) && (|w_src_match);

    // ------------------------------------------------------------------
    // FSM state
    // ------------------------------------------------------------------
    logic [1:0] r_state;
    logic [2:0] r_cnt;
    logic [1:0] r_saved_state;
    logic [2:0] r_saved_cnt;

    logic [1:0] w_nxt_state;
    logic [2:0] w_nxt_cnt;
    logic [1:0] w_nxt_saved_state;
    logic [2:0] w_nxt_saved_cnt;

    // When waitrequest drops, the saved context acts in that same cycle.
    // No cycle is lost on resume, and a pending branch can act at once.
    // The saved state is never MEM_WAIT, because it is only loaded from
    // the effective state.
    logic [1:0] w_eff_state;
    logic [2:0] w_eff_cnt;
    assign w_eff_state = (r_state == c_ST_WAIT) ? r_saved_state : r_state;
    assign w_eff_cnt   = (r_state == c_ST_WAIT) ? r_saved_cnt   : r_cnt;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= c_ST_RUN;
            r_cnt         <= 3'd0;
            r_saved_state <= c_ST_RUN;
            r_saved_cnt   <= 3'd0;
        end else begin
            r_state       <= w_nxt_state;
            r_cnt         <= w_nxt_cnt;
            r_saved_state <= w_nxt_saved_state;
            r_saved_cnt   <= w_nxt_saved_cnt;
        end
    end

    // Next-state logic. Priority is waitrequest, then branch, then load-use.
    always_comb begin
        w_nxt_state       = r_state;
        w_nxt_cnt         = r_cnt;
        w_nxt_saved_state = r_saved_state;
        w_nxt_saved_cnt   = r_saved_cnt;
        if (o_p_waitrequest) begin
            w_nxt_state       = c_ST_WAIT;
            w_nxt_saved_state = w_eff_state;
            w_nxt_saved_cnt   = w_eff_cnt;
        end else if (PCSrcE) begin
            w_nxt_state = c_ST_RUN;
            w_nxt_cnt   = 3'd0;
        end else begin
            case (w_eff_state)
                c_ST_LU: begin
                    if (w_eff_cnt <= 3'd1) begin
                        w_nxt_state = c_ST_RUN;
                        w_nxt_cnt   = 3'd0;
                    end else begin
                        w_nxt_state = c_ST_LU;
                        w_nxt_cnt   = w_eff_cnt - 3'd1;
                    end
                end
                default: begin
                    if (w_load_use && c_MULTI) begin
                        w_nxt_state = c_ST_LU;
                        w_nxt_cnt   = c_LU_INIT;
                    end else begin
                        w_nxt_state = c_ST_RUN;
                        w_nxt_cnt   = 3'd0;
                    end
                end
            endcase
        end
    end

    // Output logic. Reset gates every control output directly, so an
    // assertion of reset mid-stall takes effect without waiting for a clock.
    logic w_stall;
    logic w_flush_d;
    logic w_flush_e;
    logic w_freeze;

    always_comb begin
        w_stall   = 1'b0;
        w_flush_d = 1'b0;
        w_flush_e = 1'b0;
        w_freeze  = 1'b0;
        if (!rst) begin
            w_stall = 1'b0;
        end else if (o_p_waitrequest) begin
            w_stall  = 1'b1;
            w_freeze = 1'b1;
        end else if (PCSrcE) begin
            w_flush_d = 1'b1;
            w_flush_e = 1'b1;
        end else begin
            case (w_eff_state)
                c_ST_LU: begin
                    w_stall   = 1'b1;
                    w_flush_e = 1'b1;
                end
                default: begin
                    w_stall   = w_load_use;
                    w_flush_e = w_load_use;
                end
            endcase
        end
    end

    assign StallF    = w_stall;
    assign StallD    = w_stall;
    assign FlushD    = w_flush_d;
    assign FlushE    = w_flush_e;
    assign FreezeEMW = w_freeze;

`ifdef HAZARD_PERF_CNT_EN
    // ------------------------------------------------------------------
    // Saturating performance counters
    // ------------------------------------------------------------------
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= 32'd0;
            r_flush_cnt <= 32'd0;
        end else if (perf_clr) begin
            r_stall_cnt <= 32'd0;
            r_flush_cnt <= 32'd0;
        end else begin
            if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (w_flush_d && (r_flush_cnt != 32'hFFFF_FFFF)) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`endif

endmodule
`default_nettype wire

// File: doc/hazard_ctrl_unit.md
HAZARD_CTRL_UNIT -- requirements
Module: hazard_ctrl_unit

Interface
REQ-001 Parameters SHALL be declared as follows, one per line:
- NUM_SRC, 2: source operands per instruction, legal 1..3.
- REG_AW, 5: register address width.
- LOAD_LAT, 1: load-use stall cycles, legal 1..4.

REQ-002 Ports SHALL be as follows (name, direction, width, meaning), one per line:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- Rs_D  in  NUM_SRC*REG_AW  decode-stage source addresses, operand i at bits [i*REG_AW +: REG_AW].
- Rs_E  in  NUM_SRC*REG_AW  execute-stage source addresses, same packing.
- RD_E  in  REG_AW  execute-stage destination.
- RegWriteE  in  1  execute instruction writes a register.
- ResultSrcE  in  1  execute instruction is a load.
- RD_M  in  REG_AW  memory-stage destination.
- RegWriteM  in  1  memory-stage write enable.
- RD_W  in  REG_AW  writeback-stage destination.
- RegWriteW  in  1  writeback-stage write enable.
- PCSrcE  in  1  taken branch/jump resolved in execute.
- o_p_waitrequest  in  1  cache busy; whole pipeline must hold.
- Forward_E  out  2*NUM_SRC  per-operand forward select: 00 regfile, 10 from M, 01 from W.
- StallF  out  1  hold PC.
- StallD  out  1  hold F/D register.
- FlushD  out  1  clear F/D register to NOP.
- FlushE  out  1  clear D/E register to bubble.
- FreezeEMW  out  1  hold D/E, E/M, M/W registers.
- perf_clr  in  1  synchronous clear of perf counters (only with macro).
- stall_cnt  out  32  load-use plus wait stall cycles (only with macro).
- flush_cnt  out  32  branch flush events (only with macro).

Function
REQ-003 Forward_E operand i SHALL be 10 when RegWriteM, RD_M != 0 and RD_M == Rs_E[i]; else 01 when RegWriteW, RD_W != 0 and RD_W == Rs_E[i]; else 00 (M has priority, combinational).
REQ-004 A load-use hazard SHALL exist when ResultSrcE & RegWriteE & RD_E != 0 & RD_E equals any Rs_D operand.
REQ-005 The FSM SHALL have three states: RUN, LU_STALL and MEM_WAIT.
REQ-006 In RUN, a hazard SHALL assert StallF, StallD and FlushE in the same cycle. If LOAD_LAT > 1, the FSM SHALL enter LU_STALL with cnt = LOAD_LAT-1; otherwise it stays in RUN.
REQ-007 In LU_STALL, StallF, StallD and FlushE SHALL be asserted and cnt decremented each cycle; the FSM SHALL return to RUN the cycle after cnt reaches 1.
REQ-008 A load-use stall SHALL total exactly LOAD_LAT cycles.
REQ-009 PCSrcE = 1 (not frozen) SHALL assert FlushD and FlushE, deassert StallF and StallD, and force the FSM to RUN, aborting any LU_STALL.
REQ-010 o_p_waitrequest = 1 SHALL assert StallF, StallD and FreezeEMW, deassert FlushD and FlushE, and place the FSM in MEM_WAIT, saving the prior state and cnt.
REQ-011 On o_p_waitrequest falling, the FSM SHALL restore the saved state and cnt. A PCSrcE still high SHALL then take effect (REQ-009) that same cycle.
REQ-012 Priority SHALL be waitrequest > branch > load-use.
REQ-013 All outputs SHALL be combinational from inputs and FSM state; there is zero added latency.

Reset
REQ-014 While rst = 0: FSM = RUN, cnt = 0, saved state = RUN, counters = 0; all stall, flush and freeze outputs = 0 regardless of other inputs; Forward_E remains combinational.
REQ-015 Reset asserted mid-stall SHALL abandon the stall immediately (asynchronously).

Configuration
REQ-016 With HAZARD_PERF_CNT_EN defined, stall_cnt SHALL increment each cycle StallF = 1, and flush_cnt SHALL increment each cycle FlushD = 1 (unfrozen).
REQ-017 Both counters SHALL saturate at 32'hFFFF_FFFF and clear on perf_clr.
REQ-018 Without HAZARD_PERF_CNT_EN, perf_clr, stall_cnt, flush_cnt and their logic SHALL be absent.

Verification
REQ-019 RD_M = 5, RegWriteM = 1, RD_W = 5, RegWriteW = 1, Rs_E = {5,5} -> Forward_E = 4'b1010; with RD_M = 0 -> 4'b0101.
REQ-020 LOAD_LAT = 3, load RD_E = 7, Rs_D[1] = 7 -> StallF, StallD and FlushE high for exactly 3 cycles, then low.
REQ-021 LOAD_LAT = 3: PCSrcE pulses in the 2nd stall cycle -> FlushD = FlushE = 1, StallF = 0, FSM RUN next cycle.
REQ-022 o_p_waitrequest high for 4 cycles during the 1st LU_STALL cycle -> FreezeEMW high for 4 cycles, then the 2 remaining stall cycles complete.
REQ-023 rst low during LU_STALL -> all stall outputs 0 immediately. With HAZARD_PERF_CNT_EN, preload near saturation -> stall_cnt holds at 32'hFFFF_FFFF.
